arp_nexthop_lookup: RTL
=======================

// Module: arp_nexthop_lookup
// PURPOSE
//  Resolves a next-hop IPv4 address to a destination MAC through a software-loaded ARP table.
//  Sits directly upstream of the MAC-rewrite / TTL-decrement stage.
//  Takes {next_hop, oq} from the LPM stage and returns dest_mac, arp_hit and oq_reg to that stage.
//  Sequential scan, one entry per cycle.
//  Keeps hit/miss statistics for the register block.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  width of register-block ports (stats, reset, table data)
//  ARP_DEPTH_BITS      5   log2 of table entries; N = 2**ARP_DEPTH_BITS = 32
// PORTS
//  AXI_ACLK        in   1    single clock
//  AXI_RESETN      in   1    reset, asynchronous, active-low
//  lookup_valid    in   1    LPM stage presents a request
//  lookup_ready    out  1    block accepts a request (high only in IDLE)
//  lookup_ip       in   32   next-hop IPv4 address
//  lookup_oq       in   8    one-hot output port from LPM (1, 4, 16, 64)
//  result_valid    out  1    result registers valid
//  result_ack      in   1    downstream consumed result (start of packet)
//  arp_hit         out  1    match found
//  dest_mac        out  48   matched MAC; 0 on miss
//  oq_reg          out  32   {24'd0, lookup_oq} captured at accept
//  tbl_wr_en       in   1    write one table entry
//  tbl_addr        in   ARP_DEPTH_BITS  write/read index
//  tbl_ip          in   32   entry IP; 0 = invalid entry
//  tbl_mac_low     in   32   entry MAC[31:0]
//  tbl_mac_high    in   32   entry MAC[47:32] in bits [15:0]
//  tbl_rd_ip       out  32   entry[tbl_addr].ip, combinational read-back
//  tbl_rd_mac      out  48   entry[tbl_addr].mac, combinational read-back
//  reset           in   32   value 32'd1 clears statistics
//  arp_hit_count   out  32   lookups resolved as hit
//  arp_miss_count  out  32   lookups resolved as miss
// BEHAVIOUR
//  Reset (AXI_RESETN=0): state IDLE; all outputs 0 except lookup_ready=1; all table entries 0 (invalid).
//  FSM states:
//   - IDLE: lookup_ready=1. lookup_valid captures ip/oq, sets idx=0, goes to SEARCH.
//   - SEARCH: compares entry[idx].ip against the captured ip, one entry per cycle.
//       Match: latch mac, arp_hit=1, go to DONE.
//       No match at idx=N-1: arp_hit=0, dest_mac=0, go to DONE.
//       Otherwise idx+1.
//   - DONE: result_valid=1, outputs held stable. result_ack returns to IDLE next cycle.
//  Latency: hit at index k gives result_valid k+1 cycles after accept; miss gives N cycles.
//  No request is accepted in the same cycle as result_ack (min 1 IDLE cycle between lookups).
//  Matching rules:
//   - Lowest index wins on duplicate IPs.
//   - Entries with ip==0 never match; lookup_ip==0 always misses.
//  Table writes are accepted in any state and take effect the next cycle.
//   - A write to the entry being compared in the same cycle: the compare uses the old contents.
//   - Entries already passed are not rescanned.
//  Counters:
//   - +1 on the SEARCH->DONE transition (hit or miss), wrap at 2**32.
//   - reset==32'd1 holds both counters at 0 (takes priority over increment).
//   - reset does not touch the FSM or the table.
//  Async reset mid-SEARCH/DONE aborts the lookup, drops result_valid immediately and clears the table.
// STRUCTURE
//  Shared package nf10_router_pkg:
//   - one-hot port constants (PORT0=8'h01, PORT1=8'h04, PORT2=8'h10, PORT3=8'h40)
//   - ARP_ENTRY_W=80, IP_INVALID=32'd0, state encodings.
//  Sub-module arp_table_regfile: N x 80-bit storage, one sync write port,
//   one combinational read port for the scan index and one for tbl_addr.
//  FSM, capture registers and counters live in arp_nexthop_lookup.
// TESTING
//  1. Load entry 3 = {10.0.0.2, 00:11:22:33:44:55}; lookup 10.0.0.2, oq=4
//     -> result_valid 4 cycles after accept, arp_hit=1, dest_mac=48'h001122334455, oq_reg=4, hit_count=1.
//  2. Lookup 10.0.0.9 (absent) -> result_valid after 32 cycles, arp_hit=0, dest_mac=0, miss_count=1.
//  3. Same IP in entries 5 and 2 with different MACs -> entry 2 MAC returned, latency 3.
//  4. Hold result_ack=0 for 10 cycles -> outputs stable and lookup_ready=0 throughout;
//     result_ack=1 -> IDLE and ready=1 next cycle.
//  5. Write entry 7 while the scan is at idx 7 -> old contents used;
//     write entry 20 at idx 7 -> new entry matched at 20.
//  6. reset=1 after 3 hits -> counters read 0.
//     Deassert AXI_RESETN during SEARCH -> result_valid=0, ready=1, table reads 0.

Source files
------------

// File: rtl/nf10_router_pkg.sv
// Shared router types: one-hot output ports, ARP entry layout and
// lookup FSM state encodings.
package nf10_router_pkg;

  localparam logic [7:0] PORT0 = 8'h01;
  localparam logic [7:0] PORT1 = 8'h04;
  localparam logic [7:0] PORT2 = 8'h10;
  localparam logic [7:0] PORT3 = 8'h40;

  localparam int ARP_ENTRY_W = 80;
  localparam logic [31:0] IP_INVALID = 32'd0;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
  } arp_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } arp_state_t;

  function automatic logic ip_match(
    input arp_entry_t e,
    input logic [31:0] ip
  );
    return (e.ip == ip) && (e.ip != IP_INVALID);
  endfunction

endpackage

// File: rtl/arp_table_regfile.sv
// ARP table storage: one sync write port, two combinational reads
// (scan index and register-block index).
module arp_table_regfile
  import nf10_router_pkg::*;
#(
  parameter int DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  arp_entry_t            wr_data,
  input  logic [DEPTH_BITS-1:0] scan_addr,
  output arp_entry_t            scan_data,
  input  logic [DEPTH_BITS-1:0] rd_addr,
  output arp_entry_t            rd_data
);

  localparam int N = 2 ** DEPTH_BITS;

  arp_entry_t mem [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign scan_data = mem[scan_addr];
  assign rd_data   = mem[rd_addr];

endmodule

// File: rtl/arp_nexthop_lookup.sv
// Next-hop IPv4 to MAC resolution by sequential scan of the ARP table,
// with hit/miss statistics.
module arp_nexthop_lookup
  import nf10_router_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int ARP_DEPTH_BITS     = 5
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESETN,
  input  logic                          lookup_valid,
  output logic                          lookup_ready,
  input  logic [31:0]                   lookup_ip,
  input  logic [7:0]                    lookup_oq,
  output logic                          result_valid,
  input  logic                          result_ack,
  output logic                          arp_hit,
  output logic [47:0]                   dest_mac,
  output logic [C_S_AXI_DATA_WIDTH-1:0] oq_reg,
  input  logic                          tbl_wr_en,
  input  logic [ARP_DEPTH_BITS-1:0]     tbl_addr,
  input  logic [31:0]                   tbl_ip,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_mac_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_mac_high,
  output logic [31:0]                   tbl_rd_ip,
  output logic [47:0]                   tbl_rd_mac,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] reset,
  output logic [C_S_AXI_DATA_WIDTH-1:0] arp_hit_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] arp_miss_count
);

  localparam logic [ARP_DEPTH_BITS-1:0] LAST_IDX = '1;
  localparam int PAD_W = C_S_AXI_DATA_WIDTH - 8;

  arp_state_t state;
  logic [ARP_DEPTH_BITS-1:0] idx;
  logic [31:0] cap_ip;
  arp_entry_t wr_entry;
  arp_entry_t scan_entry;
  arp_entry_t rd_entry;
  logic scan_hit;
  logic scan_end;
  logic unused_mac_hi;

  assign wr_entry.ip  = tbl_ip;
  assign wr_entry.mac = {tbl_mac_high[15:0], tbl_mac_low[31:0]};
  assign unused_mac_hi = ^tbl_mac_high[C_S_AXI_DATA_WIDTH-1:16];

  arp_table_regfile #(
    .DEPTH_BITS (ARP_DEPTH_BITS)
  ) u_tbl (
    .clk       (AXI_ACLK),
    .rst_n     (AXI_RESETN),
    .wr_en     (tbl_wr_en),
    .wr_addr   (tbl_addr),
    .wr_data   (wr_entry),
    .scan_addr (idx),
    .scan_data (scan_entry),
    .rd_addr   (tbl_addr),
    .rd_data   (rd_entry)
  );

  assign tbl_rd_ip  = rd_entry.ip;
  assign tbl_rd_mac = rd_entry.mac;

  // Invalid entries never match, so a zero lookup_ip always misses.
  assign scan_hit = ip_match(scan_entry, cap_ip);
  assign scan_end = (state == ST_SEARCH) && (scan_hit || idx == LAST_IDX);

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state        <= ST_IDLE;
      idx          <= '0;
      cap_ip       <= '0;
      oq_reg       <= '0;
      arp_hit      <= 1'b0;
      dest_mac     <= '0;
      result_valid <= 1'b0;
      lookup_ready <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (lookup_valid) begin
            cap_ip       <= lookup_ip;
            oq_reg       <= {{PAD_W{1'b0}}, lookup_oq};
            idx          <= '0;
            lookup_ready <= 1'b0;
            state        <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (scan_hit) begin
            arp_hit      <= 1'b1;
            dest_mac     <= scan_entry.mac;
            result_valid <= 1'b1;
            state        <= ST_DONE;
          end else if (idx == LAST_IDX) begin
            arp_hit      <= 1'b0;
            dest_mac     <= '0;
            result_valid <= 1'b1;
            state        <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            lookup_ready <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state        <= ST_IDLE;
          result_valid <= 1'b0;
          lookup_ready <= 1'b1;
        end
      endcase
    end
  end

  // Stats clear wins over a same-cycle increment.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      arp_hit_count  <= '0;
      arp_miss_count <= '0;
    end else if (reset == C_S_AXI_DATA_WIDTH'(1)) begin
      arp_hit_count  <= '0;
      arp_miss_count <= '0;
    end else if (scan_end) begin
      if (scan_hit) begin
        arp_hit_count <= arp_hit_count + 1'b1;
      end else begin
        arp_miss_count <= arp_miss_count + 1'b1;
      end
    end
  end

endmodule
